cpu_run_ctrl: RTL
=================

Name: cpu_run_ctrl

Overview:
- Run/step/breakpoint controller sitting between board inputs (switches, keys) and the `cpu` core.
- Sequences the core through `cpu_en` (a global stall / clock-enable) and a soft reset `cpu_rst_n`.
- Halts the core on a PC breakpoint and counts retired cycles.
- Synchronises the raw switch bank onto the core's `GPIO_in` so the core never samples asynchronous inputs.

Parameters:
- RST_CYCLES, 4, cycles `cpu_rst_n` is held low in RESET_HOLD (≥1).
- AUTO_RUN, 1, 1: RESET_HOLD exits to RUNNING; 0: exits to HALTED.
- PC_W, 12, width of the PC / breakpoint address.
- SW_W, 18, width of the raw switch bank.

Ports:
- clk  in  1  system clock, same clock as `cpu`.
- rst_n  in  1  asynchronous active-low reset.
- sw_raw  in  SW_W  asynchronous switch inputs.
- run_key  in  1  asynchronous level; rising edge = run request.
- step_key  in  1  asynchronous level; rising edge = single-step request.
- halt_key  in  1  asynchronous level; rising edge = halt request.
- srst_key  in  1  asynchronous level; rising edge = soft-reset request.
- bp_en  in  1  breakpoint enable (quasi-static).
- bp_addr  in  PC_W  breakpoint PC (quasi-static).
- pc  in  PC_W  current fetch PC from `cpu`.
- GPIO_in  out  32  synchronised switches to `cpu`, zero-extended from SW_W.
- cpu_en  out  1  core advance enable (combinational from state).
- cpu_rst_n  out  1  soft reset to `cpu`, registered, active-low.
- state_o  out  2  current state encoding.
- halted_pc  out  PC_W  PC captured on entry to HALTED.
- cycle_cnt  out  32  count of cycles with `cpu_en`=1.

Behaviour:
- **Reset (rst_n=0, async):**
  - state=RESET_HOLD, hold counter=0, `cpu_rst_n`=0, `cpu_en`=0.
  - `GPIO_in`=0, `halted_pc`=0, `cycle_cnt`=0, all synchroniser flops 0, bp_skip=0.
- **Synchronisers:**
  - Each key and `sw_raw` passes through 2 flops.
  - Keys get a 3rd flop for edge detect: req = s2 & ~s3.
  - A key rising edge sampled at edge k produces req during cycle k+1 → state update at edge k+2.
  - `GPIO_in` = s2 of `sw_raw`, latency 2 edges.
- **Request priority:** srst > halt > step > run. Only one request acts per cycle; lower-priority requests in the same cycle are dropped.
- **States:**
  - RESET_HOLD=0: `cpu_rst_n`=0, `cycle_cnt` cleared. After RST_CYCLES cycles → RUNNING if AUTO_RUN, else HALTED.
  - HALTED=1.
  - RUNNING=2.
  - STEP=3.
- **Transitions:**
  - srst req from any state → RESET_HOLD, hold counter restarted. This also applies mid-RESET_HOLD.
  - RUNNING: halt req → HALTED.
  - RUNNING: bp_hit → HALTED.
  - HALTED: step req → STEP.
  - HALTED: run req → RUNNING.
  - HALTED: halt req ignored.
  - STEP → HALTED unconditionally after exactly 1 cycle. Requests other than srst arriving during STEP are dropped.
  - RUNNING: run req ignored; step req ignored.
- **Breakpoint:**
  - bp_hit = bp_en & (pc==bp_addr) & ~bp_skip & state==RUNNING.
  - bp_skip is set on any exit from HALTED whose PC equals bp_addr, so resume does not re-trap on the same instruction.
  - bp_skip clears on the first cycle pc≠bp_addr, and in RESET_HOLD.
- **cpu_en:**
  - `cpu_en` = (state==RUNNING & ~bp_hit) | state==STEP.
  - The instruction at bp_addr is therefore NOT executed on a hit.
- **cpu_rst_n:** registered; 1 in every state except RESET_HOLD. Its rising edge is coincident with the exit from RESET_HOLD.
- **halted_pc:** loaded with `pc` on every transition into HALTED, whether by halt, breakpoint, step completion or AUTO_RUN=0 exit.
- **cycle_cnt:** +1 on each cycle `cpu_en`=1; saturates at 32'hFFFF_FFFF; no wrap.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - typedef enum logic [1:0] run_state_t {RESET_HOLD, HALTED, RUNNING, STEP};
  - CNT_MAX constant.
- One sub-module, sync_edge: parameterised-width 2-flop synchroniser with optional rising-edge output. It is instanced for the key bundle (width 4, edge on) and for `sw_raw` (edge off).

Test Plan:
- Reset then AUTO_RUN=1 → `cpu_rst_n`=0 for 4 cycles after rst_n release, then `cpu_en`=1, state_o=2, `cycle_cnt` increments 1/cycle.
- sw_raw=18'h00011 → `GPIO_in`=32'h0000_0011 exactly 2 edges later; change to 18'h3F000 → 32'h0003_F000 two edges later.
- bp_en=1, bp_addr=12'h010, pc walks 0x000, 0x004, … → `cpu_en`=0 in the cycle pc=0x010, state_o=1, `halted_pc`=12'h010, `cycle_cnt`=4.
  - Then run_key → core resumes at 0x010 without re-trap.
- From HALTED: step_key pulse → `cpu_en` high exactly 1 cycle, `cycle_cnt` +1, back to HALTED.
  - step_key + run_key same cycle → STEP only.
- RUNNING: srst_key while halt_key also rises → RESET_HOLD wins, `cycle_cnt`=0, `cpu_rst_n` low 4 cycles.
  - Second srst mid-hold restarts the count.
- Preload `cycle_cnt` near max (force 32'hFFFF_FFFE), run 3 cycles → holds at 32'hFFFF_FFFF; async rst_n mid-RUNNING → all outputs at reset values immediately.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the CPU run/step/breakpoint controller.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    RESET_HOLD = 2'd0,
    HALTED     = 2'd1,
    RUNNING    = 2'd2,
    STEP       = 2'd3
  } run_state_t;

  typedef enum logic [2:0] {
    REQ_NONE,
    REQ_RUN,
    REQ_STEP,
    REQ_HALT,
    REQ_SRST
  } req_t;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  // Bit positions of the keys inside the synchronised key bundle.
  localparam int unsigned KEY_N    = 4;
  localparam int unsigned KEY_RUN  = 0;
  localparam int unsigned KEY_STEP = 1;
  localparam int unsigned KEY_HALT = 2;
  localparam int unsigned KEY_SRST = 3;

  // Only the most important pending request survives a cycle.
  function automatic req_t pick_req(input logic [KEY_N-1:0] rise);
    if (rise[KEY_SRST]) return REQ_SRST;
    if (rise[KEY_HALT]) return REQ_HALT;
    if (rise[KEY_STEP]) return REQ_STEP;
    if (rise[KEY_RUN])  return REQ_RUN;
    return REQ_NONE;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for a bundle of asynchronous inputs, with an optional
// third flop providing a one-cycle rising-edge pulse per bit.
module sync_edge #(
  parameter int unsigned W       = 1,
  parameter bit          EDGE_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

  generate
    if (EDGE_EN) begin : g_edge
      logic [W-1:0] s3_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s3_q <= '0;
        else        s3_q <= s2_q;
      end

      assign rise_o = s2_q & ~s3_q;
    end else begin : g_no_edge
      assign rise_o = '0;
    end
  endgenerate

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint sequencer for the cpu core: drives its clock-enable and
// soft reset, traps on a PC breakpoint and counts cycles the core advanced.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES = 4,
  parameter bit          AUTO_RUN   = 1'b1,
  parameter int unsigned PC_W       = 12,
  parameter int unsigned SW_W       = 18
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SW_W-1:0] sw_raw,
  input  logic            run_key,
  input  logic            step_key,
  input  logic            halt_key,
  input  logic            srst_key,
  input  logic            bp_en,
  input  logic [PC_W-1:0] bp_addr,
  input  logic [PC_W-1:0] pc,
  output logic [31:0]     GPIO_in,
  output logic            cpu_en,
  output logic            cpu_rst_n,
  output logic [1:0]      state_o,
  output logic [PC_W-1:0] halted_pc,
  output logic [31:0]     cycle_cnt
);

  localparam int unsigned      HOLD_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);

  run_state_t        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic [PC_W-1:0]   halted_pc_q, halted_pc_d;
  logic [31:0]       cycle_cnt_q, cycle_cnt_d;
  logic              bp_skip_q, bp_skip_d;

  logic [KEY_N-1:0]  key_rise;
  logic [KEY_N-1:0]  key_lvl_unused;
  logic [SW_W-1:0]   sw_sync;
  logic [SW_W-1:0]   sw_rise_unused;
  req_t              req_c;
  logic              pc_at_bp_c;
  logic              bp_hit_c;

  sync_edge #(.W(KEY_N), .EDGE_EN(1'b1)) u_key_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    ({srst_key, halt_key, step_key, run_key}),
    .q_o    (key_lvl_unused),
    .rise_o (key_rise)
  );

  sync_edge #(.W(SW_W), .EDGE_EN(1'b0)) u_sw_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (sw_raw),
    .q_o    (sw_sync),
    .rise_o (sw_rise_unused)
  );

  assign req_c      = pick_req(key_rise);
  assign pc_at_bp_c = (pc == bp_addr);
  assign bp_hit_c   = bp_en & pc_at_bp_c & ~bp_skip_q & (state_q == RUNNING);
  // A hit stalls the core before the breakpoint instruction executes.
  assign cpu_en     = ((state_q == RUNNING) & ~bp_hit_c) | (state_q == STEP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESET_HOLD;
      hold_q      <= '0;
      cpu_rst_n_q <= 1'b0;
      halted_pc_q <= '0;
      cycle_cnt_q <= '0;
      bp_skip_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      halted_pc_q <= halted_pc_d;
      cycle_cnt_q <= cycle_cnt_d;
      bp_skip_q   <= bp_skip_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    halted_pc_d = halted_pc_q;
    cycle_cnt_d = cycle_cnt_q;
    bp_skip_d   = bp_skip_q;

    if (req_c == REQ_SRST) begin
      state_d = RESET_HOLD;
      hold_d  = '0;
    end else begin
      case (state_q)
        RESET_HOLD: begin
          if (hold_q == HOLD_LAST) state_d = AUTO_RUN ? RUNNING : HALTED;
          else                     hold_d  = hold_q + HOLD_W'(1);
        end
        HALTED: begin
          if (req_c == REQ_STEP)     state_d = STEP;
          else if (req_c == REQ_RUN) state_d = RUNNING;
        end
        RUNNING: begin
          if (req_c == REQ_HALT || bp_hit_c) state_d = HALTED;
        end
        STEP:    state_d = HALTED;
        default: state_d = RESET_HOLD;
      endcase
    end

    // Registered so its release lines up with leaving RESET_HOLD.
    cpu_rst_n_d = (state_d != RESET_HOLD);

    if (state_d == HALTED && state_q != HALTED) halted_pc_d = pc;

    // Lets a resume from the breakpoint PC execute it instead of re-trapping.
    if (state_q == RESET_HOLD)                                bp_skip_d = 1'b0;
    else if (state_q == HALTED && state_d != HALTED && pc_at_bp_c) bp_skip_d = 1'b1;
    else if (!pc_at_bp_c)                                     bp_skip_d = 1'b0;

    if (state_d == RESET_HOLD)                    cycle_cnt_d = '0;
    else if (cpu_en && cycle_cnt_q != CNT_MAX)    cycle_cnt_d = cycle_cnt_q + 32'd1;
  end

  assign GPIO_in   = 32'(sw_sync);
  assign cpu_rst_n = cpu_rst_n_q;
  assign state_o   = state_q;
  assign halted_pc = halted_pc_q;
  assign cycle_cnt = cycle_cnt_q;

endmodule
